// File: rtl/execute_muldiv_stage.sv
// ---------------------------------------------------------------------------
// execute_muldiv_stage
//
// Execute-stage M-extension unit combined with the E->M pipeline register.
//   - MUL/MULH/MULHSU/MULHU finish in the same cycle as ordinary ALU ops.
//   - DIV/DIVU/REM/REMU run a 32-iteration restoring divider. The divider
//     holds E via StallE and feeds bubbles into M until the result is ready.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   RegWriteE..RdE    E-stage control fields, copied into M
//   ALUResultE        upstream ALU result (used when MulDivE=0)
//   WriteDataE        store data, copied into M
//   SrcAE, SrcBE      rs1 / rs2 operands for the M-extension op
//   MulDivE, funct3E  M-extension select and operation code
//   RegWriteM..RdM    registered M-stage control fields
//   ALUResultM        registered ALU result, product, quotient or remainder
//   WriteDataM        registered store data
//   StallE            combinational; 1 = upstream must hold E inputs
// ---------------------------------------------------------------------------
module execute_muldiv_stage #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteE,
    input  logic            ResultSrcE,
    input  logic            MemWriteE,
    input  logic            MemTypeE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            MulDivE,
    input  logic [2:0]      funct3E,
    output logic            RegWriteM,
    output logic            ResultSrcM,
    output logic            MemWriteM,
    output logic            MemTypeM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic            StallE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [4:0]      LAST_ITER = 5'(DIV_ITERS - 1);
    localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic [4:0]      r_count;
    logic [XLEN-1:0] r_rem;          // partial remainder
    logic [XLEN-1:0] r_quo;          // dividend shifting out / quotient shifting in
    logic [XLEN-1:0] r_divisor;      // |divisor|
    logic [XLEN-1:0] r_dividend_raw; // original rs1, needed for x/0 remainder
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_is_rem;
    logic            r_div_zero;
    logic            r_ovf;

    logic            w_div_req;
    logic [2*XLEN-1:0] w_prod_u;
    logic [XLEN-1:0] w_hi_su;
    logic [XLEN-1:0] w_hi_ss;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_alu_next;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_div_result;

    assign w_div_req = MulDivE & funct3E[2];

    // Stall request: a divide waiting in IDLE or a divide in progress
    assign StallE = ((r_state == S_IDLE) & w_div_req) | (r_state == S_RUN);

    // Multiplier: one unsigned 64-bit product, signed high halves derived by
    // subtracting the two's-complement correction terms (a31*b, b31*a).
    always_comb begin
        w_prod_u = {ZERO, SrcAE} * {ZERO, SrcBE};
        w_hi_su  = w_prod_u[2*XLEN-1:XLEN] - (SrcAE[XLEN-1] ? SrcBE : ZERO);
        w_hi_ss  = w_hi_su - (SrcBE[XLEN-1] ? SrcAE : ZERO);
        case (funct3E[1:0])
            2'b00:   w_mul_res = w_prod_u[XLEN-1:0];
            2'b01:   w_mul_res = w_hi_ss;
            2'b10:   w_mul_res = w_hi_su;
            2'b11:   w_mul_res = w_prod_u[2*XLEN-1:XLEN];
            default: w_mul_res = w_prod_u[XLEN-1:0];
        endcase
        if (MulDivE) begin
            w_alu_next = w_mul_res;
        end else begin
            w_alu_next = ALUResultE;
        end
    end

    // Divider operand preparation: magnitudes for the signed variants
    always_comb begin
        w_a_neg = ~funct3E[0] & SrcAE[XLEN-1];
        w_b_neg = ~funct3E[0] & SrcBE[XLEN-1];
        if (w_a_neg) begin
            w_a_abs = ZERO - SrcAE;
        end else begin
            w_a_abs = SrcAE;
        end
        if (w_b_neg) begin
            w_b_abs = ZERO - SrcBE;
        end else begin
            w_b_abs = SrcBE;
        end
    end

    // One restoring shift-subtract step; bit XLEN of the trial is the borrow
    always_comb begin
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_trial = w_shift - {1'b0, r_divisor};
        w_ge    = ~w_trial[XLEN];
    end

    // Final sign fix-up and corner-case override applied in DONE
    always_comb begin
        if (r_q_neg) begin
            w_quo_fix = ZERO - r_quo;
        end else begin
            w_quo_fix = r_quo;
        end
        if (r_r_neg) begin
            w_rem_fix = ZERO - r_rem;
        end else begin
            w_rem_fix = r_rem;
        end
        if (r_div_zero) begin
            w_quo_fix = ALL_ONES;
            w_rem_fix = r_dividend_raw;
        end else if (r_ovf) begin
            w_quo_fix = MOST_NEG;
            w_rem_fix = ZERO;
        end else begin
            w_quo_fix = w_quo_fix;
            w_rem_fix = w_rem_fix;
        end
        if (r_is_rem) begin
            w_div_result = w_rem_fix;
        end else begin
            w_div_result = w_quo_fix;
        end
    end

    // Divider FSM, divider datapath and E->M pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_count        <= 5'd0;
            r_rem          <= ZERO;
            r_quo          <= ZERO;
            r_divisor      <= ZERO;
            r_dividend_raw <= ZERO;
            r_q_neg        <= 1'b0;
            r_r_neg        <= 1'b0;
            r_is_rem       <= 1'b0;
            r_div_zero     <= 1'b0;
            r_ovf          <= 1'b0;
            RegWriteM      <= 1'b0;
            ResultSrcM     <= 1'b0;
            MemWriteM      <= 1'b0;
            MemTypeM       <= 1'b0;
            RdM            <= 5'd0;
            ALUResultM     <= ZERO;
            WriteDataM     <= ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_div_req) begin
                        r_state        <= S_RUN;
                        r_count        <= 5'd0;
                        r_rem          <= ZERO;
                        r_quo          <= w_a_abs;
                        r_divisor      <= w_b_abs;
                        r_dividend_raw <= SrcAE;
                        r_q_neg        <= w_a_neg ^ w_b_neg;
                        r_r_neg        <= w_a_neg;
                        r_is_rem       <= funct3E[1];
                        r_div_zero     <= (SrcBE == ZERO);
                        r_ovf          <= ~funct3E[0] & (SrcAE == MOST_NEG) & (SrcBE == ALL_ONES);
                        RegWriteM      <= 1'b0;
                        ResultSrcM     <= 1'b0;
                        MemWriteM      <= 1'b0;
                        MemTypeM       <= 1'b0;
                        RdM            <= 5'd0;
                        ALUResultM     <= ZERO;
                        WriteDataM     <= ZERO;
                    end else begin
                        r_state    <= S_IDLE;
                        RegWriteM  <= RegWriteE;
                        ResultSrcM <= ResultSrcE;
                        MemWriteM  <= MemWriteE;
                        MemTypeM   <= MemTypeE;
                        RdM        <= RdE;
                        ALUResultM <= w_alu_next;
                        WriteDataM <= WriteDataE;
                    end
                end
                S_RUN: begin
                    r_quo      <= {r_quo[XLEN-2:0], w_ge};
                    if (w_ge) begin
                        r_rem <= w_trial[XLEN-1:0];
                    end else begin
                        r_rem <= w_shift[XLEN-1:0];
                    end
                    if (r_count == LAST_ITER) begin
                        r_state <= S_DONE;
                        r_count <= 5'd0;
                    end else begin
                        r_state <= S_RUN;
                        r_count <= r_count + 5'd1;
                    end
                    RegWriteM  <= 1'b0;
                    ResultSrcM <= 1'b0;
                    MemWriteM  <= 1'b0;
                    MemTypeM   <= 1'b0;
                    RdM        <= 5'd0;
                    ALUResultM <= ZERO;
                    WriteDataM <= ZERO;
                end
                S_DONE: begin
                    // E is still holding the divide, so its control fields
                    // describe the instruction being retired here.
                    r_state    <= S_IDLE;
                    RegWriteM  <= RegWriteE;
                    ResultSrcM <= ResultSrcE;
                    MemWriteM  <= MemWriteE;
                    MemTypeM   <= MemTypeE;
                    RdM        <= RdE;
                    ALUResultM <= w_div_result;
                    WriteDataM <= WriteDataE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_count    <= 5'd0;
                    RegWriteM  <= 1'b0;
                    ResultSrcM <= 1'b0;
                    MemWriteM  <= 1'b0;
                    MemTypeM   <= 1'b0;
                    RdM        <= 5'd0;
                    ALUResultM <= ZERO;
                    WriteDataM <= ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_muldiv_stage
//
// Self-checking bench for execute_muldiv_stage. Expected values come from a
// plain-arithmetic reference (64-bit products, SV integer division) and from
// the fixed latency of a divide (result on the 34th edge after the request).
// ---------------------------------------------------------------------------
module tb_execute_muldiv_stage;

    logic        clk;
    logic        rst_n;
    logic        RegWriteE, ResultSrcE, MemWriteE, MemTypeE;
    logic [4:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE, SrcAE, SrcBE;
    logic        MulDivE;
    logic [2:0]  funct3E;
    logic        RegWriteM, ResultSrcM, MemWriteM, MemTypeM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallE;

    int n_cmp  = 0;
    int n_fail = 0;

    execute_muldiv_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .MemTypeE   (MemTypeE),
        .RdE        (RdE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .MulDivE    (MulDivE),
        .funct3E    (funct3E),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .MemTypeM   (MemTypeM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallE     (StallE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference multiply from full-width products
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        case (f)
            2'b00: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
            2'b01: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
            2'b10: begin sp = longint'($signed(a)) * longint'({32'h0, b}); return sp[63:32]; end
            default: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
        endcase
    endfunction

    // Reference divide/remainder including the RISC-V corner cases
    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
            sa = $signed(a);
            sb = $signed(b);
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    task automatic drive_nop();
        RegWriteE  = 1'b0; ResultSrcE = 1'b0; MemWriteE = 1'b0; MemTypeE = 1'b0;
        RdE = 5'd0; ALUResultE = 32'h0; WriteDataE = 32'h0;
        SrcAE = 32'h0; SrcBE = 32'h0; MulDivE = 1'b0; funct3E = 3'b000;
    endtask

    // Issue one divide and step until M shows a register write (or budget).
    // Operands are scrambled after the request to prove they are latched.
    task automatic run_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] wd,
                           output int edge_n, output int stalls);
        RegWriteE = 1'b1; ResultSrcE = 1'b0; MemWriteE = 1'b0; MemTypeE = rd[1];
        RdE = rd; ALUResultE = $urandom; WriteDataE = wd;
        SrcAE = a; SrcBE = b; MulDivE = 1'b1; funct3E = f;
        #1;
        edge_n = 0;
        stalls = 0;
        while (edge_n < 40) begin
            if (StallE) stalls++;
            @(posedge clk); #1;
            edge_n++;
            if (RegWriteM) break;
            SrcAE = $urandom;
            SrcBE = $urandom;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (RegWriteM !== 1'b0)   begin n_fail++; $display("FAIL reset_regwrite got %b exp 0", RegWriteM); end
        n_cmp++; if (ResultSrcM !== 1'b0)  begin n_fail++; $display("FAIL reset_resultsrc got %b exp 0", ResultSrcM); end
        n_cmp++; if (MemWriteM !== 1'b0)   begin n_fail++; $display("FAIL reset_memwrite got %b exp 0", MemWriteM); end
        n_cmp++; if (MemTypeM !== 1'b0)    begin n_fail++; $display("FAIL reset_memtype got %b exp 0", MemTypeM); end
        n_cmp++; if (RdM !== 5'd0)         begin n_fail++; $display("FAIL reset_rd got %0d exp 0", RdM); end
        n_cmp++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL reset_alu got %h exp 0", ALUResultM); end
        n_cmp++; if (WriteDataM !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", WriteDataM); end
        n_cmp++; if (StallE !== 1'b0)      begin n_fail++; $display("FAIL reset_stall got %b exp 0", StallE); end
    endtask

    task automatic test_mul_directed();
        logic [1:0]  fs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] ex [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
        for (int i = 0; i < 4; i++) begin
            drive_nop();
            RegWriteE = 1'b1; RdE = 5'(i + 1);
            SrcAE = 32'hFFFF_FFFE; SrcBE = 32'h3; MulDivE = 1'b1; funct3E = {1'b0, fs[i]};
            #1;
            n_cmp++; if (StallE !== 1'b0) begin n_fail++; $display("FAIL mul_dir_stall op %0d got %b exp 0", i, StallE); end
            @(posedge clk); #1;
            n_cmp++; if (ALUResultM !== ex[i]) begin n_fail++; $display("FAIL mul_dir_result op %0d got %h exp %h", i, ALUResultM, ex[i]); end
            n_cmp++; if (RdM !== 5'(i + 1)) begin n_fail++; $display("FAIL mul_dir_rd op %0d got %0d exp %0d", i, RdM, i + 1); end
        end
    endtask

    task automatic test_mul_random();
        logic [31:0] exp_alu;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wd;
        logic        exp_rw, exp_rs, exp_mw, exp_mt;
        for (int i = 0; i < 60; i++) begin
            RegWriteE = 1'($urandom); ResultSrcE = 1'($urandom); MemWriteE = 1'($urandom);
            MemTypeE = 1'($urandom); RdE = 5'($urandom); ALUResultE = $urandom;
            WriteDataE = $urandom; MulDivE = 1'($urandom); funct3E = {1'b0, 2'($urandom)};
            case (i % 4)
                0: begin SrcAE = $urandom; SrcBE = $urandom; end
                1: begin SrcAE = 32'h8000_0000; SrcBE = $urandom; end
                2: begin SrcAE = $urandom; SrcBE = 32'hFFFF_FFFF; end
                default: begin SrcAE = 32'($urandom_range(0, 100)); SrcBE = 32'h8000_0000; end
            endcase
            exp_alu = MulDivE ? ref_mul(funct3E[1:0], SrcAE, SrcBE) : ALUResultE;
            exp_rd = RdE; exp_wd = WriteDataE;
            exp_rw = RegWriteE; exp_rs = ResultSrcE; exp_mw = MemWriteE; exp_mt = MemTypeE;
            #1;
            n_cmp++; if (StallE !== 1'b0) begin n_fail++; $display("FAIL mul_rnd_stall iter %0d got %b exp 0", i, StallE); end
            @(posedge clk); #1;
            n_cmp++; if (ALUResultM !== exp_alu) begin n_fail++; $display("FAIL mul_rnd_result iter %0d f3 %0d got %h exp %h", i, funct3E, ALUResultM, exp_alu); end
            n_cmp++; if ({RegWriteM, ResultSrcM, MemWriteM, MemTypeM, RdM, WriteDataM} !== {exp_rw, exp_rs, exp_mw, exp_mt, exp_rd, exp_wd})
                begin n_fail++; $display("FAIL mul_rnd_ctrl iter %0d got %b%b%b%b rd %0d wd %h exp %b%b%b%b rd %0d wd %h", i,
                    RegWriteM, ResultSrcM, MemWriteM, MemTypeM, RdM, WriteDataM, exp_rw, exp_rs, exp_mw, exp_mt, exp_rd, exp_wd); end
        end
        drive_nop();
    endtask

    task automatic test_div_directed();
        int e, s;
        logic [2:0]  fs [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 6; i++) begin
            run_div(fs[i], as[i], bs[i], 5'd5, 32'hA5A5_0000 + 32'(i), e, s);
            n_cmp++; if (e !== 34) begin n_fail++; $display("FAIL div_dir_latency case %0d got %0d exp 34", i, e); end
            n_cmp++; if (s !== 33) begin n_fail++; $display("FAIL div_dir_stall case %0d got %0d exp 33", i, s); end
            n_cmp++; if (ALUResultM !== ex[i]) begin n_fail++; $display("FAIL div_dir_result case %0d got %h exp %h", i, ALUResultM, ex[i]); end
            n_cmp++; if (RdM !== 5'd5) begin n_fail++; $display("FAIL div_dir_rd case %0d got %0d exp 5", i, RdM); end
            n_cmp++; if (WriteDataM !== 32'hA5A5_0000 + 32'(i)) begin n_fail++; $display("FAIL div_dir_wdata case %0d got %h", i, WriteDataM); end
            drive_nop();
        end
    endtask

    task automatic test_div_random();
        int e, s;
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        logic [4:0]  rd;
        for (int i = 0; i < 10; i++) begin
            f = {1'b1, 2'($urandom)};
            a = $urandom;
            case (i % 3)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20)) ^ {32{1'($urandom)}};
                default: b = (i == 2) ? 32'h0 : 32'($urandom_range(0, 7));
            endcase
            exp = ref_div(f, a, b);
            rd = 5'($urandom_range(1, 31));
            run_div(f, a, b, rd, 32'h0, e, s);
            n_cmp++; if (e !== 34) begin n_fail++; $display("FAIL div_rnd_latency iter %0d got %0d exp 34", i, e); end
            n_cmp++; if (ALUResultM !== exp) begin n_fail++; $display("FAIL div_rnd_result iter %0d f3 %0d a %h b %h got %h exp %h", i, f, a, b, ALUResultM, exp); end
            n_cmp++; if ({RdM, MemTypeM, MemWriteM} !== {rd, rd[1], 1'b0}) begin n_fail++; $display("FAIL div_rnd_ctrl iter %0d rd got %0d exp %0d", i, RdM, rd); end
            drive_nop();
        end
    endtask

    task automatic test_back_to_back();
        int e, s;
        run_div(3'b101, 32'd10, 32'd3, 5'd7, 32'h0, e, s);
        n_cmp++; if (e !== 34) begin n_fail++; $display("FAIL b2b_first_latency got %0d exp 34", e); end
        n_cmp++; if (ALUResultM !== 32'd3) begin n_fail++; $display("FAIL b2b_first_result got %h exp 3", ALUResultM); end
        run_div(3'b111, 32'd10, 32'd3, 5'd8, 32'h0, e, s);
        n_cmp++; if (e !== 34) begin n_fail++; $display("FAIL b2b_second_latency got %0d exp 34 (edge 68 overall)", e); end
        n_cmp++; if (ALUResultM !== 32'd1) begin n_fail++; $display("FAIL b2b_second_result got %h exp 1", ALUResultM); end
        n_cmp++; if (RdM !== 5'd8) begin n_fail++; $display("FAIL b2b_second_rd got %0d exp 8", RdM); end
        drive_nop();
        @(posedge clk); #1;
        n_cmp++; if (RegWriteM !== 1'b0) begin n_fail++; $display("FAIL b2b_no_duplicate got %b exp 0", RegWriteM); end
    endtask

    task automatic test_abort();
        int e, s;
        drive_nop();
        RegWriteE = 1'b1; RdE = 5'd9; SrcAE = 32'hFFFF_FFF9; SrcBE = 32'd2;
        MulDivE = 1'b1; funct3E = 3'b100;
        repeat (11) @(posedge clk);
        #1;
        n_cmp++; if (StallE !== 1'b1) begin n_fail++; $display("FAIL abort_running got %b exp 1", StallE); end
        rst_n = 1'b0;
        drive_nop();
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (StallE !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %b exp 0", StallE); end
        n_cmp++; if ({RegWriteM, ResultSrcM, MemWriteM, MemTypeM, RdM, ALUResultM, WriteDataM} !== 73'h0)
            begin n_fail++; $display("FAIL abort_outputs rw %b rd %0d alu %h exp all zero", RegWriteM, RdM, ALUResultM); end
        repeat (25) @(posedge clk);
        #1;
        n_cmp++; if (RegWriteM !== 1'b0) begin n_fail++; $display("FAIL abort_no_partial got %b exp 0", RegWriteM); end
        run_div(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'h0, e, s);
        n_cmp++; if (e !== 34) begin n_fail++; $display("FAIL abort_redo_latency got %0d exp 34", e); end
        n_cmp++; if (ALUResultM !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL abort_redo_result got %h exp fffffffd", ALUResultM); end
        drive_nop();
    endtask

    initial begin
        test_reset();
        test_mul_directed();
        test_mul_random();
        test_div_directed();
        test_div_random();
        test_back_to_back();
        test_abort();
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
